// File: rtl/tri_host_pkg.sv
// tri_host_pkg: shared types and constants for the triangle host.
// Holds the FSM state encoding, grid geometry and the field positions
// inside the 18-bit packed triangle command {x1,y1,x2,y2,x3,y3}.
package tri_host_pkg;

    localparam int GRID_W  = 8;
    localparam int COORD_W = 3;
    localparam int CELLS   = GRID_W * GRID_W;
    localparam int IDX_W   = 2 * COORD_W;
    localparam int CNT_W   = 7;
    localparam int VTX_W   = 6 * COORD_W;

    // LSB position of each coordinate field inside cmd_vtx
    localparam int X1_LSB = 15;
    localparam int Y1_LSB = 12;
    localparam int X2_LSB = 9;
    localparam int Y2_LSB = 6;
    localparam int X3_LSB = 3;
    localparam int Y3_LSB = 0;

    // Only vertices 2 and 3 need to be stored; vertex 1 is driven at acceptance
    localparam int VTX_TAIL_W = 4 * COORD_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_V1      = 3'd1,
        ST_V2      = 3'd2,
        ST_V3      = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_COLLECT = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Bitmap cell index for a point: row-major, y selects the byte
    function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/tri_host_frame.sv
// tri_host_frame: 8x8 coverage bitmap with distinct-pixel count and a
// sticky duplicate flag. clear_i wipes everything at command acceptance;
// record_i marks one point per cycle.
module tri_host_frame
    import tri_host_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               record_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [CELLS-1:0]   frame_o,
    output logic [CNT_W-1:0]   pix_cnt_o,
    output logic               dup_o
);

    logic [CELLS-1:0] frame_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dup_q;
    logic [IDX_W-1:0] idx;

    assign idx = cell_idx(x_i, y_i);

    // Set a new bit and count it, or flag a repeat hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
        end else if (clear_i) begin
            frame_q <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
        end else if (record_i) begin
            if (frame_q[idx]) begin
                dup_q <= 1'b1;
            end else begin
                frame_q[idx] <= 1'b1;
                cnt_q        <= cnt_q + 1'b1;
            end
        end
    end

    assign frame_o   = frame_q;
    assign pix_cnt_o = cnt_q;
    assign dup_o     = dup_q;

endmodule

// File: rtl/tri_host.sv
// tri_host: accepts one triangle command, serialises its vertices onto
// nt/xi/yi, then collects rasteriser points into a coverage bitmap.
// Optional macro TRI_HOST_WATCHDOG_EN adds rise/collect timeouts that
// abort to DONE with err set; without it err is tied low.
// Command handshake: a command transfers on a rising edge where
// cmd_valid && cmd_ready; cmd_ready is high only while the FSM is idle.
module tri_host
    import tri_host_pkg::*;
`ifdef TRI_HOST_WATCHDOG_EN
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int RISE_MAX    = 4
)
`endif
(
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [VTX_W-1:0]   cmd_vtx,
    output logic               nt,
    output logic [COORD_W-1:0] xi,
    output logic [COORD_W-1:0] yi,
    input  logic               busy,
    input  logic               po,
    input  logic [COORD_W-1:0] xo,
    input  logic [COORD_W-1:0] yo,
    output logic [CELLS-1:0]   frame,
    output logic [CNT_W-1:0]   pix_cnt,
    output logic               dup,
    output logic               done,
    output logic               err
);

    state_t                  state_q;
    logic [VTX_TAIL_W-1:0]   vtx_q;
    logic                    ready_q;
    logic                    nt_q;
    logic [COORD_W-1:0]      xi_q;
    logic [COORD_W-1:0]      yi_q;
    logic                    done_q;
    logic                    accept;
    logic                    record;

`ifdef TRI_HOST_WATCHDOG_EN
    localparam int WD_MAX = (TIMEOUT_CYC > RISE_MAX) ? TIMEOUT_CYC : RISE_MAX;
    localparam int WD_W   = $clog2(WD_MAX + 1);
    logic [WD_W-1:0] wd_cnt_q;
    logic            err_q;
`endif

    assign accept = cmd_valid && ready_q;
    assign record = (state_q == ST_COLLECT) && po;

    // Main FSM: vertex serialiser plus collect/done sequencing, all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            vtx_q    <= '0;
            ready_q  <= 1'b1;
            nt_q     <= 1'b0;
            xi_q     <= '0;
            yi_q     <= '0;
            done_q   <= 1'b0;
`ifdef TRI_HOST_WATCHDOG_EN
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            nt_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        vtx_q   <= cmd_vtx[VTX_TAIL_W-1:0];
                        ready_q <= 1'b0;
                        nt_q    <= 1'b1;
                        xi_q    <= cmd_vtx[X1_LSB +: COORD_W];
                        yi_q    <= cmd_vtx[Y1_LSB +: COORD_W];
                        state_q <= ST_V1;
`ifdef TRI_HOST_WATCHDOG_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                ST_V1: begin
                    xi_q    <= vtx_q[X2_LSB +: COORD_W];
                    yi_q    <= vtx_q[Y2_LSB +: COORD_W];
                    state_q <= ST_V2;
                end
                ST_V2: begin
                    xi_q    <= vtx_q[X3_LSB +: COORD_W];
                    yi_q    <= vtx_q[Y3_LSB +: COORD_W];
                    state_q <= ST_V3;
                end
                ST_V3: begin
                    state_q  <= ST_WAIT_HI;
`ifdef TRI_HOST_WATCHDOG_EN
                    wd_cnt_q <= '0;
`endif
                end
                ST_WAIT_HI: begin
                    if (busy) begin
                        state_q  <= ST_COLLECT;
`ifdef TRI_HOST_WATCHDOG_EN
                        wd_cnt_q <= '0;
                    end else if (wd_cnt_q == WD_W'(RISE_MAX)) begin
                        err_q    <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (!busy) begin
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
`ifdef TRI_HOST_WATCHDOG_EN
                    end else if (wd_cnt_q == WD_W'(TIMEOUT_CYC)) begin
                        err_q    <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    tri_host_frame u_frame (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (accept),
        .record_i  (record),
        .x_i       (xo),
        .y_i       (yo),
        .frame_o   (frame),
        .pix_cnt_o (pix_cnt),
        .dup_o     (dup)
    );

    assign cmd_ready = ready_q;
    assign nt        = nt_q;
    assign xi        = xi_q;
    assign yi        = yi_q;
    assign done      = done_q;
`ifdef TRI_HOST_WATCHDOG_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: doc/tri_host.md
Name: tri_host

Overview:
- Host-side partner of the triangle rasteriser interface (nt/xi/yi in, busy/po/xo/yo out).
- Accepts one triangle command from an upstream producer.
- Serialises the three vertices onto nt/xi/yi over three consecutive cycles.
- Collects every emitted point (po/xo/yo) into an 8x8 coverage bitmap with pixel count, then signals completion.

Parameters:
- TIMEOUT_CYC, 255: max COLLECT cycles before abort (used only with the optional feature).
- RISE_MAX, 4: max WAIT_HI cycles for busy to rise (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  triangle command valid.
- cmd_ready  out  1  host can accept a command (IDLE only).
- cmd_vtx  in  18  {x1,y1,x2,y2,x3,y3}, 3 bits each, x1 in [17:15].
- nt  out  1  new-triangle strobe to rasteriser.
- xi  out  3  vertex x to rasteriser.
- yi  out  3  vertex y to rasteriser.
- busy  in  1  rasteriser busy.
- po  in  1  point-valid from rasteriser.
- xo  in  3  point x.
- yo  in  3  point y.
- frame  out  64  coverage bitmap; bit index = yo*8+xo.
- pix_cnt  out  7  number of distinct bits set in frame (0..64).
- dup  out  1  sticky: a po hit an already-set bit this triangle.
- done  out  1  one-cycle pulse at end of triangle.
- err  out  1  sticky abort flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values: cmd_ready=1, nt=0, xi=0, yi=0, frame=0, pix_cnt=0, dup=0, done=0, err=0; state=IDLE. Reset mid-operation returns to IDLE immediately.
- All outputs are registered.
- States: IDLE, V1, V2, V3, WAIT_HI, COLLECT, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
  - latch cmd_vtx;
  - clear frame, pix_cnt, dup, err;
  - go to V1.
- V1: nt=1, xi/yi=x1/y1. V2: nt=0, xi/yi=x2/y2. V3: xi/yi=x3/y3.
- Vertex timing: nt is high for exactly one cycle; vertices appear on three consecutive cycles; first vertex is on the bus the cycle after acceptance.
- After V3 go to WAIT_HI.
- xi/yi hold their last value outside V1..V3; nt is 0 outside V1.
- WAIT_HI: stay until busy==1, then go to COLLECT. If busy is already high in V3, WAIT_HI still lasts one cycle.
- COLLECT, each cycle with po==1, for bit b=yo*8+xo:
  - if frame[b]==0: set it, pix_cnt+=1;
  - else set dup.
- COLLECT exit: when busy==0, go to DONE. A po sampled in that same cycle is still recorded.
- DONE: done=1 for one cycle, then IDLE.
- frame, pix_cnt and dup hold until the next command is accepted.
- po outside COLLECT is ignored, and no state changes.
- busy high while in IDLE does not block acceptance; the upstream producer guarantees one triangle at a time.
- pix_cnt saturation is impossible (at most 64 distinct bits).
- Coordinates are unsigned 3-bit; no arithmetic beyond the index (yo<<3)|xo.
- Latency: acceptance at edge T gives nt high during cycle T+1. done fires the cycle after busy is first sampled low in COLLECT.

Optional Feature:
- Macro: TRI_HOST_WATCHDOG_EN.
- When defined:
  - WAIT_HI lasting more than RISE_MAX cycles, or COLLECT exceeding TIMEOUT_CYC cycles, sets err=1 and goes to DONE (done pulses);
  - frame keeps the points collected so far.
- When undefined: no counters, err is constant 0, and WAIT_HI/COLLECT wait indefinitely.

Decomposition:
- Shared package holds:
  - state enum (IDLE..DONE);
  - GRID_W=8 and COORD_W=3;
  - the 18-bit cmd_vtx field-slice constants.
- One natural sub-module, tri_host_frame: the bitmap, pix_cnt and dup logic with clear/record inputs.
- The FSM and vertex serialiser stay in tri_host.

Test Plan:
- Reset mid-COLLECT (stub busy high, 2 points recorded), assert reset → all outputs return to reset values; cmd_ready=1 on the next cycle.
- cmd_vtx=(1,1),(3,1),(1,3) accepted at T → nt=1 only in T+1; xi/yi = 1/1, 3/1, 1/3 in T+1..T+3; cmd_ready=0 from T+1 until after done.
- Stub rasteriser raises busy in V3, emits po at (0,0),(1,0),(0,1), drops busy → frame=0x0000_0000_0000_0103, pix_cnt=3, dup=0, one-cycle done.
- Stub emits (7,7) twice → frame bit 63 set, pix_cnt=1, dup=1.
- Stub emits po at (2,5) in the same cycle busy falls → bit 42 set, pix_cnt=1, done next cycle.
- With TRI_HOST_WATCHDOG_EN: stub never raises busy → err=1 and done after RISE_MAX+1 WAIT_HI cycles. Without the macro, the same stimulus keeps the FSM in WAIT_HI.
